regfile_write_queue: RTL and testbench

Write-request buffer that sits directly upstream of the register file write port. It accepts write requests via a valid/ready handshake and holds them in a DEPTH-entry FIFO. It issues them one per cycle, in order, on a registered write_enable/write_addr/write_data port that connects straight to the register file. It also reports, for a given read address, whether a write is still pending in the queue, and returns the youngest pending data for forwarding.

---
 rtl/regfile_write_queue.sv | 127 ++++++++++++
 tb/tb_regfile_write_queue.sv | 231 +++++++++++++++++++++++
 2 files changed

// File: rtl/regfile_write_queue.sv
// regfile_write_queue
//   In-order write-request buffer in front of a register file write port.
//   Requests enter via a valid/ready handshake into a DEPTH-entry FIFO. They
//   are issued one per cycle onto a registered write port. A combinational
//   probe reports whether a write to read_addr_i is still pending, and returns
//   the youngest pending data for forwarding.
//
// Ports
//   clk_i, rst_ni          clock, asynchronous active-low reset
//   req_valid_i/ready_o    request handshake; ready is !full (no push-through)
//   req_addr_i/data_i      request payload
//   drain_enable_i         permits an issue this cycle
//   write_enable_o/addr_o/data_o  registered register-file write port
//   read_addr_i            probe address
//   hit_o/hit_data_o       pending-write probe result (data 0 on miss)
//   count_o/full_o/empty_o queue occupancy (excludes the issued register)
module regfile_write_queue #(
    parameter  int N     = 8,
    parameter  int M     = 4,
    parameter  int DEPTH = 4,
    localparam int A     = $clog2(M),
    localparam int C     = $clog2(DEPTH) + 1
) (
    input  logic         clk_i,
    input  logic         rst_ni,
    input  logic         req_valid_i,
    output logic         req_ready_o,
    input  logic [A-1:0] req_addr_i,
    input  logic [N-1:0] req_data_i,
    input  logic         drain_enable_i,
    output logic         write_enable_o,
    output logic [A-1:0] write_addr_o,
    output logic [N-1:0] write_data_o,
    input  logic [A-1:0] read_addr_i,
    output logic         hit_o,
    output logic [N-1:0] hit_data_o,
    output logic [C-1:0] count_o,
    output logic         full_o,
    output logic         empty_o
);

    localparam int PW = C - 1;  // index width; pointer MSB is the wrap bit

    logic [A-1:0] mem_addr_q [DEPTH];
    logic [N-1:0] mem_data_q [DEPTH];

    logic [C-1:0] wr_ptr_q, wr_ptr_d;
    logic [C-1:0] rd_ptr_q, rd_ptr_d;
    logic         we_q,     we_d;
    logic [A-1:0] waddr_q,  waddr_d;
    logic [N-1:0] wdata_q,  wdata_d;

    logic push, pop;
    logic [PW-1:0] idx;

    // Occupancy from the pointer difference; the wrap bit disambiguates full.
    assign count_o     = wr_ptr_q - rd_ptr_q;
    assign full_o      = (count_o == C'(DEPTH));
    assign empty_o     = (count_o == '0);
    assign req_ready_o = !full_o;

    assign push = req_valid_i && !full_o;
    assign pop  = !empty_o && drain_enable_i;

    assign write_enable_o = we_q;
    assign write_addr_o   = waddr_q;
    assign write_data_o   = wdata_q;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        we_d     = 1'b0;
        waddr_d  = waddr_q;
        wdata_d  = wdata_q;
        if (push) wr_ptr_d = wr_ptr_q + C'(1);
        if (pop) begin
            rd_ptr_d = rd_ptr_q + C'(1);
            we_d     = 1'b1;
            waddr_d  = mem_addr_q[rd_ptr_q[PW-1:0]];
            wdata_d  = mem_data_q[rd_ptr_q[PW-1:0]];
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            we_q     <= 1'b0;
            waddr_q  <= '0;
            wdata_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            we_q     <= we_d;
            waddr_q  <= waddr_d;
            wdata_q  <= wdata_d;
        end
    end

    // Storage is not reset; entries outside [rd_ptr, wr_ptr) are never read.
    always_ff @(posedge clk_i) begin
        if (push) begin
            mem_addr_q[wr_ptr_q[PW-1:0]] <= req_addr_i;
            mem_data_q[wr_ptr_q[PW-1:0]] <= req_data_i;
        end
    end

    // Probe: start at the output register (oldest), then walk the queue from
    // head to tail so the youngest matching entry is the last to overwrite.
    always_comb begin
        hit_o      = 1'b0;
        hit_data_o = '0;
        idx        = '0;
        if (we_q && (waddr_q == read_addr_i)) begin
            hit_o      = 1'b1;
            hit_data_o = wdata_q;
        end
        for (int i = 0; i < DEPTH; i++) begin
            idx = rd_ptr_q[PW-1:0] + PW'(i);
            if ((C'(i) < count_o) && (mem_addr_q[idx] == read_addr_i)) begin
                hit_o      = 1'b1;
                hit_data_o = mem_data_q[idx];
            end
        end
    end

endmodule

// File: tb/tb_regfile_write_queue.sv
module tb_regfile_write_queue;

    localparam int N = 8, M = 4, DEPTH = 4;

    typedef struct packed {
        logic [1:0] a;
        logic [7:0] d;
    } ent_t;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       req_valid = 1'b0;
    logic       req_ready;
    logic [1:0] req_addr = '0;
    logic [7:0] req_data = '0;
    logic       drain = 1'b0;
    logic       we;
    logic [1:0] wa;
    logic [7:0] wd;
    logic [1:0] read_addr = '0;
    logic       hit;
    logic [7:0] hit_data;
    logic [2:0] count;
    logic       full, empty;

    int checks = 0;
    int failures = 0;

    // Reference model: scoreboard queue of accepted-but-not-issued requests
    ent_t       mq[$];
    ent_t       e;
    logic       exp_we = 1'b0;
    logic [1:0] exp_wa = '0;
    logic [7:0] exp_wd = '0;
    bit         acc, iss;

    regfile_write_queue #(.N(N), .M(M), .DEPTH(DEPTH)) dut (
        .clk_i(clk), .rst_ni(rst_n),
        .req_valid_i(req_valid), .req_ready_o(req_ready),
        .req_addr_i(req_addr), .req_data_i(req_data),
        .drain_enable_i(drain),
        .write_enable_o(we), .write_addr_o(wa), .write_data_o(wd),
        .read_addr_i(read_addr), .hit_o(hit), .hit_data_o(hit_data),
        .count_o(count), .full_o(full), .empty_o(empty)
    );

    always #5 clk = ~clk;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mq.delete();
            exp_we = 1'b0;
            exp_wa = '0;
            exp_wd = '0;
        end else begin
            acc = req_valid && (mq.size() < DEPTH);
            iss = drain && (mq.size() > 0);
            if (iss) begin
                e = mq.pop_front();
                exp_we = 1'b1;
                exp_wa = e.a;
                exp_wd = e.d;
            end else begin
                exp_we = 1'b0;
            end
            if (acc) mq.push_back('{a: req_addr, d: req_data});
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    // Compare every output against the model.
    task automatic chk_all();
        logic       h;
        logic [7:0] hd;
        h = 1'b0;
        hd = '0;
        if (exp_we && exp_wa == read_addr) begin h = 1'b1; hd = exp_wd; end
        foreach (mq[i]) if (mq[i].a == read_addr) begin h = 1'b1; hd = mq[i].d; end
        chk("write_enable", 32'(we), 32'(exp_we));
        chk("write_addr",   32'(wa), 32'(exp_wa));
        chk("write_data",   32'(wd), 32'(exp_wd));
        chk("count",        32'(count), 32'(mq.size()));
        chk("full",         32'(full), 32'(mq.size() == DEPTH));
        chk("empty",        32'(empty), 32'(mq.size() == 0));
        chk("req_ready",    32'(req_ready), 32'(mq.size() != DEPTH));
        chk("hit",          32'(hit), 32'(h));
        chk("hit_data",     32'(hit_data), 32'(hd));
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        chk_all();
    endtask

    task automatic drive(input logic v, input logic [1:0] a, input logic [7:0] d);
        req_valid = v;
        req_addr  = a;
        req_data  = d;
    endtask

    initial begin
        // Reset state
        #2;
        chk_all();
        chk("reset_empty", 32'(empty), 32'd1);
        #20;
        @(posedge clk); #1;
        rst_n = 1'b1;

        // Single request: issue exactly one edge after acceptance
        drain = 1'b1;
        drive(1'b1, 2'd1, 8'h0A);
        tick();
        chk("t1_count_after_push", 32'(count), 32'd1);
        chk("t1_we_not_yet", 32'(we), 32'd0);
        drive(1'b0, 2'd0, 8'h00);
        tick();
        chk("t1_we", 32'(we), 32'd1);
        chk("t1_addr", 32'(wa), 32'd1);
        chk("t1_data", 32'(wd), 32'h0A);
        chk("t1_count_after_issue", 32'(count), 32'd0);
        tick();
        chk("t1_we_drop", 32'(we), 32'd0);

        // Fill to full, 5th push refused, then drain in order
        drain = 1'b0;
        for (int i = 0; i < 4; i++) begin
            drive(1'b1, 2'(i), 8'(8'h11 * (i + 1)));
            tick();
        end
        chk("t2_full", 32'(full), 32'd1);
        chk("t2_ready", 32'(req_ready), 32'd0);
        drive(1'b1, 2'd0, 8'h55);
        tick();
        chk("t2_count_hold", 32'(count), 32'd4);
        drive(1'b0, 2'd0, 8'h00);
        drain = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tick();
            chk("t2_issue_data", 32'(wd), 32'(8'h11 * (i + 1)));
            chk("t2_issue_we", 32'(we), 32'd1);
        end
        chk("t2_empty", 32'(empty), 32'd1);
        tick();

        // Duplicate addresses: youngest wins on the probe
        drain = 1'b0;
        drive(1'b1, 2'd2, 8'hF0);
        tick();
        drive(1'b1, 2'd2, 8'h0F);
        tick();
        drive(1'b0, 2'd0, 8'h00);
        read_addr = 2'd2;
        #1;
        chk_all();
        chk("t3_hit", 32'(hit), 32'd1);
        chk("t3_hit_data", 32'(hit_data), 32'h0F);
        read_addr = 2'd3;
        #1;
        chk_all();
        chk("t3_miss", 32'(hit), 32'd0);
        chk("t3_miss_data", 32'(hit_data), 32'd0);

        // Steady push+pop with 2 queued, pointers wrap several times
        drain = 1'b1;
        for (int i = 0; i < 10; i++) begin
            drive(1'b1, 2'(i), 8'(8'hA0 + i));
            read_addr = 2'(i + 1);
            tick();
            chk("t4_count_steady", 32'(count), 32'd2);
        end
        drive(1'b0, 2'd0, 8'h00);
        repeat (3) tick();
        chk("t4_empty", 32'(empty), 32'd1);

        // Asynchronous reset with 3 queued and write_enable high
        drain = 1'b0;
        for (int i = 0; i < 4; i++) begin
            drive(1'b1, 2'(3 - i), 8'(8'hC0 + i));
            tick();
        end
        drive(1'b0, 2'd0, 8'h00);
        drain = 1'b1;
        read_addr = 2'd3;
        tick();
        chk("t5_pre_we", 32'(we), 32'd1);
        chk("t5_pre_count", 32'(count), 32'd3);
        rst_n = 1'b0;
        #1;
        chk("t5_rst_we", 32'(we), 32'd0);
        chk("t5_rst_addr", 32'(wa), 32'd0);
        chk("t5_rst_data", 32'(wd), 32'd0);
        chk("t5_rst_count", 32'(count), 32'd0);
        chk("t5_rst_empty", 32'(empty), 32'd1);
        chk("t5_rst_full", 32'(full), 32'd0);
        chk("t5_rst_ready", 32'(req_ready), 32'd1);
        chk("t5_rst_hit", 32'(hit), 32'd0);
        chk("t5_rst_hit_data", 32'(hit_data), 32'd0);
        drive(1'b1, 2'd1, 8'h99);  // dropped: reset still low at this edge
        tick();
        rst_n = 1'b1;
        drive(1'b1, 2'd2, 8'h77);
        tick();
        drive(1'b0, 2'd0, 8'h00);
        tick();
        chk("t5_first_after_rst_we", 32'(we), 32'd1);
        chk("t5_first_after_rst_data", 32'(wd), 32'h77);
        chk("t5_first_after_rst_addr", 32'(wa), 32'd2);

        // Empty queue with drain held: nothing issues, port holds
        for (int i = 0; i < 5; i++) begin
            tick();
            chk("t6_we_idle", 32'(we), 32'd0);
            chk("t6_data_hold", 32'(wd), 32'h77);
            chk("t6_addr_hold", 32'(wa), 32'd2);
        end
        chk("t6_scoreboard_drained", 32'(mq.size()), 32'(count));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
